// File: rtl/apb_regbank_pkg.sv
// ---------------------------------------------------------------------------
// apb_regbank_pkg
// Shared types and helpers for the APB register bank.
//   apb_state_e     : APB slave FSM states (IDLE, SETUP, ACCESS)
//   MAX_WAIT_STATES : largest supported number of extra ACCESS cycles
//   lane_count()    : number of byte lanes in a data word
//   even_parity8()  : even-parity bit of one byte lane
// ---------------------------------------------------------------------------
package apb_regbank_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int unsigned MAX_WAIT_STATES = 32'd15;

  function automatic int unsigned lane_count(input int unsigned data_width);
    return data_width / 32'd8;
  endfunction

  // Parity bit that makes the lane plus its parity bit hold an even number of ones.
  function automatic logic even_parity8(input logic [7:0] byte_val);
    return ^byte_val;
  endfunction

endpackage

// File: rtl/apb_regbank_storage.sv
// ---------------------------------------------------------------------------
// apb_regbank_storage
// Word array behind the APB register bank: byte-lane strobed writes,
// combinational read port and (optionally) per-lane even parity.
// Optional feature macro: APB_REGBANK_PARITY_EN (adds par_inject input and
// per-lane parity storage/check).
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset (clears all words)
//   wr_en            : commit a write this cycle
//   wr_idx           : word index of the write
//   wr_data, wr_strb : write data and byte-lane enables
//   par_inject       : (parity build only) invert stored parity of written lanes
//   rd_idx           : word index of the read
//   rd_data          : stored word at rd_idx
//   rd_par_err       : some lane of rd_idx fails its parity check
// ---------------------------------------------------------------------------
module apb_regbank_storage
  import apb_regbank_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_WORDS  = 64,
  parameter int unsigned MEM_IDX_W  = 6
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    wr_en,
  input  logic [MEM_IDX_W-1:0]    wr_idx,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
`ifdef APB_REGBANK_PARITY_EN
  input  logic                    par_inject,
`endif
  input  logic [MEM_IDX_W-1:0]    rd_idx,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_par_err
);

  localparam int unsigned LANES = lane_count(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem_r [NUM_WORDS];

  // Word array: cleared on reset, only strobed lanes of the addressed word change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int w = 0; w < int'(NUM_WORDS); w++) begin
        mem_r[w] <= '0;
      end
    end else if (wr_en) begin
      for (int b = 0; b < int'(LANES); b++) begin
        if (wr_strb[b]) begin
          mem_r[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  // The caller only uses rd_data for in-range indices.
  assign rd_data = mem_r[rd_idx];

`ifdef APB_REGBANK_PARITY_EN
  logic [LANES-1:0] par_r [NUM_WORDS];
  logic [LANES-1:0] rd_calc_par_s;

  // Parity array: follows the data lanes; par_inject corrupts the stored bit on purpose.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int w = 0; w < int'(NUM_WORDS); w++) begin
        par_r[w] <= '0;
      end
    end else if (wr_en) begin
      for (int b = 0; b < int'(LANES); b++) begin
        if (wr_strb[b]) begin
          par_r[wr_idx][b] <= even_parity8(wr_data[b*8 +: 8]) ^ par_inject;
        end
      end
    end
  end

  // Recompute parity of the word being read, lane by lane.
  always_comb begin
    rd_calc_par_s = '0;
    for (int b = 0; b < int'(LANES); b++) begin
      rd_calc_par_s[b] = even_parity8(rd_data[b*8 +: 8]);
    end
  end

  assign rd_par_err = |(rd_calc_par_s ^ par_r[rd_idx]);
`else
  assign rd_par_err = 1'b0;
`endif

endmodule

// File: rtl/apb_register_bank.sv
// ---------------------------------------------------------------------------
// apb_register_bank
// Parametrised APB3/APB4 slave register bank with byte strobes, programmable
// wait states, out-of-range error response and registered read data.
// Optional feature macro: APB_REGBANK_PARITY_EN (per-lane parity, par_inject
// port, parity errors reported through pslverr on reads).
// Ports:
//   clk, reset_n          : clock (rising edge), asynchronous active-low reset
//   psel, penable, pwrite : APB control
//   paddr                 : byte address; low byte-offset bits are ignored
//   pwdata, pstrb         : write data and byte-lane strobes
//   par_inject            : (parity build only) corrupt parity of written lanes
//   pready                : registered, high for one cycle per completed transfer
//   prdata, pslverr       : registered response, zero whenever pready is low
// ---------------------------------------------------------------------------
module apb_register_bank
  import apb_regbank_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_WORDS   = 64,
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
`ifdef APB_REGBANK_PARITY_EN
  input  logic                    par_inject,
`endif
  output logic                    pready,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pslverr
);

  localparam int unsigned LANES     = lane_count(DATA_WIDTH);
  localparam int unsigned OFF_W     = $clog2(LANES);
  localparam int unsigned IDX_W     = ADDR_WIDTH - OFF_W;
  localparam int unsigned MEM_IDX_W = (NUM_WORDS > 32'd1) ? $clog2(NUM_WORDS) : 32'd1;
  localparam logic [3:0]  WAIT_LOAD =
    4'((WAIT_STATES > MAX_WAIT_STATES) ? MAX_WAIT_STATES : WAIT_STATES);

  apb_state_e            state_r;
  logic [3:0]            wait_cnt_r;
  logic                  pready_r;
  logic [DATA_WIDTH-1:0] prdata_r;
  logic                  pslverr_r;

  logic [IDX_W-1:0]      word_idx_s;
  logic [MEM_IDX_W-1:0]  mem_idx_s;
  logic                  in_range_s;
  logic                  bus_ok_s;
  logic                  resp_s;
  logic                  wr_commit_s;
  logic [DATA_WIDTH-1:0] rd_data_s;
  logic                  rd_par_err_s;
  logic                  unused_s;

  // The byte-offset bits of paddr are intentionally not decoded.
  assign unused_s = ^paddr;

  // Address decode and the two decision strobes: raise pready next cycle, commit a write now.
  always_comb begin
    word_idx_s = paddr[ADDR_WIDTH-1:OFF_W];
    in_range_s = (32'(word_idx_s) < NUM_WORDS);
    mem_idx_s  = word_idx_s[MEM_IDX_W-1:0];
    bus_ok_s   = psel & penable;
    resp_s     = 1'b0;
    // pready is registered, so it is decided one edge before the cycle it is seen in.
    case (state_r)
      SETUP: begin
        if (psel && (WAIT_LOAD == 4'd0)) begin
          resp_s = 1'b1;
        end else begin
          resp_s = 1'b0;
        end
      end
      ACCESS: begin
        if (!pready_r && bus_ok_s && (wait_cnt_r == 4'd1)) begin
          resp_s = 1'b1;
        end else begin
          resp_s = 1'b0;
        end
      end
      default: resp_s = 1'b0;
    endcase
    // Writes land on the edge that closes the pready cycle.
    if ((state_r == ACCESS) && pready_r && bus_ok_s && pwrite && in_range_s) begin
      wr_commit_s = 1'b1;
    end else begin
      wr_commit_s = 1'b0;
    end
  end

  // APB FSM with wait counter and registered response outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      wait_cnt_r <= 4'd0;
      pready_r   <= 1'b0;
      prdata_r   <= '0;
      pslverr_r  <= 1'b0;
    end else begin
      // Response registers are single-cycle pulses; zero unless a response is launched.
      pready_r  <= 1'b0;
      prdata_r  <= '0;
      pslverr_r <= 1'b0;
      if (resp_s) begin
        pready_r  <= 1'b1;
        pslverr_r <= !in_range_s || (!pwrite && rd_par_err_s);
        if (!pwrite && in_range_s) begin
          prdata_r <= rd_data_s;
        end else begin
          prdata_r <= '0;
        end
      end

      case (state_r)
        IDLE: begin
          wait_cnt_r <= 4'd0;
          if (psel && !penable) begin
            state_r <= SETUP;
          end else begin
            state_r <= IDLE;
          end
        end
        SETUP: begin
          if (psel) begin
            state_r    <= ACCESS;
            wait_cnt_r <= WAIT_LOAD;
          end else begin
            state_r    <= IDLE;
            wait_cnt_r <= 4'd0;
          end
        end
        ACCESS: begin
          if (pready_r) begin
            wait_cnt_r <= 4'd0;
            if (psel && !penable) begin
              state_r <= SETUP;
            end else begin
              state_r <= IDLE;
            end
          end else if (!bus_ok_s) begin
            // Master dropped psel or penable mid-transfer: abandon it silently.
            state_r    <= IDLE;
            wait_cnt_r <= 4'd0;
          end else if (wait_cnt_r != 4'd0) begin
            state_r    <= ACCESS;
            wait_cnt_r <= wait_cnt_r - 4'd1;
          end else begin
            // Counter empty without a response is unreachable; recover to IDLE.
            state_r    <= IDLE;
            wait_cnt_r <= 4'd0;
          end
        end
        default: begin
          state_r    <= IDLE;
          wait_cnt_r <= 4'd0;
        end
      endcase
    end
  end

  apb_regbank_storage #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_WORDS  (NUM_WORDS),
    .MEM_IDX_W  (MEM_IDX_W)
  ) u_storage (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_commit_s),
    .wr_idx     (mem_idx_s),
    .wr_data    (pwdata),
    .wr_strb    (pstrb),
`ifdef APB_REGBANK_PARITY_EN
    .par_inject (par_inject),
`endif
    .rd_idx     (mem_idx_s),
    .rd_data    (rd_data_s),
    .rd_par_err (rd_par_err_s)
  );

  assign pready  = pready_r;
  assign prdata  = prdata_r;
  assign pslverr = pslverr_r;

endmodule

// File: tb/tb_apb_register_bank.sv
// ---------------------------------------------------------------------------
// tb_apb_register_bank
// Self-checking bench: directed cases followed by random APB traffic, all
// compared against a word-array reference model built from the bank's rules.
// Configured with NUM_WORDS=48 and WAIT_STATES=3 so that out-of-range indices
// and wait-state timing are both exercised.
// ---------------------------------------------------------------------------
module tb_apb_register_bank;

  localparam int unsigned DW    = 32;
  localparam int unsigned NW    = 48;
  localparam int unsigned AW    = 12;
  localparam int unsigned WS    = 3;
  localparam int unsigned LANES = DW / 8;
`ifdef APB_REGBANK_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  // Bus ACCESS phase starts one cycle before the FSM reaches ACCESS, so the
  // pready cycle is bus-access cycle WS+2 (FSM ACCESS cycle WS+1).
  localparam int LAT = int'(WS) + 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             psel, penable, pwrite;
  logic [AW-1:0]    paddr;
  logic [DW-1:0]    pwdata;
  logic [LANES-1:0] pstrb;
  logic             par_inject;
  logic             pready;
  logic [DW-1:0]    prdata;
  logic             pslverr;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0]    ref_mem [NW];
  logic [LANES-1:0] ref_bad [NW];

  always #5 clk = ~clk;

  apb_register_bank #(
    .DATA_WIDTH  (DW),
    .NUM_WORDS   (NW),
    .ADDR_WIDTH  (AW),
    .WAIT_STATES (WS)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .pstrb      (pstrb),
`ifdef APB_REGBANK_PARITY_EN
    .par_inject (par_inject),
`endif
    .pready     (pready),
    .prdata     (prdata),
    .pslverr    (pslverr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic ref_clear();
    for (int w = 0; w < int'(NW); w++) begin
      ref_mem[w] = '0;
      ref_bad[w] = '0;
    end
  endtask

  task automatic ref_write(input int idx, input logic [DW-1:0] data,
                           input logic [LANES-1:0] strb, input logic inj);
    if (idx < int'(NW)) begin
      for (int b = 0; b < int'(LANES); b++) begin
        if (strb[b]) begin
          ref_mem[idx][b*8 +: 8] = data[b*8 +: 8];
          ref_bad[idx][b]        = inj;
        end
      end
    end
  endtask

  task automatic bus_idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
    end
  endtask

  // One complete transfer; leaves the bus in its pready cycle so a following
  // call continues back-to-back.
  task automatic apb_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [LANES-1:0] strb, input logic inj, input string tag,
                          output logic [DW-1:0] rd_obs);
    int cyc;
    int idx;
    logic seen;
    logic exp_err;
    logic [DW-1:0] exp_dat;
    idx = int'(addr) / int'(LANES);
    if (idx >= int'(NW)) begin
      exp_err = 1'b1;
      exp_dat = '0;
    end else begin
      exp_err = !wr && PAR_EN && (ref_bad[idx] != '0);
      exp_dat = ref_mem[idx];
    end
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
    pwdata = data; pstrb = strb; par_inject = inj;
    @(posedge clk); #1;
    penable = 1'b1;
    cyc = 0; seen = 1'b0; rd_obs = '0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (pready) begin
        seen = 1'b1;
        rd_obs = prdata;
      end else begin
        check({tag, " quiet"}, {31'd0, pslverr, prdata}, 64'd0);
      end
    end
    check({tag, " latency"}, 64'(cyc), 64'(LAT));
    if (seen) begin
      check({tag, " pslverr"}, {63'd0, pslverr}, {63'd0, exp_err});
      if (!wr) begin
        check({tag, " prdata"}, {32'd0, prdata}, {32'd0, exp_dat});
      end
      if (wr) begin
        ref_write(idx, data, strb, inj);
      end
    end else begin
      psel = 1'b0; penable = 1'b0;
    end
  endtask

  // Start a transfer and abandon it after k bus-access cycles (k <= WS keeps it before pready).
  task automatic apb_abort(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input int k, input logic drop_psel, input string tag);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr;
    pwdata = data; pstrb = 4'hF; par_inject = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      check({tag, " no pready"}, {63'd0, pready}, 64'd0);
    end
    @(posedge clk); #1;
    if (drop_psel) begin
      psel = 1'b0; penable = 1'b0;
    end else begin
      penable = 1'b0;
    end
    repeat (2) begin
      @(negedge clk);
      check({tag, " post no pready"}, {63'd0, pready}, 64'd0);
    end
    bus_idle(2);
  endtask

  logic [DW-1:0] obs;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; par_inject = 1'b0;
    ref_clear();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("reset outputs", {31'd0, pready, pslverr, prdata}, 64'd0);

    // Cleared word reads back as zero.
    apb_xfer(1'b0, 12'h014, 32'h0, 4'h0, 1'b0, "rd idx5", obs);
    check("rd idx5 value", {32'd0, obs}, 64'h0);

    // Full write then single-lane overwrite.
    apb_xfer(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 1'b0, "wr beef", obs);
    apb_xfer(1'b1, 12'h010, 32'h000000AA, 4'h1, 1'b0, "wr aa", obs);
    apb_xfer(1'b0, 12'h010, 32'h0, 4'h0, 1'b0, "rd beaa", obs);
    check("rd beaa value", {32'd0, obs}, 64'hDEADBEAA);

    // All-zero strobe changes nothing; offset bits ignored.
    apb_xfer(1'b1, 12'h010, 32'h11111111, 4'h0, 1'b0, "wr nostrb", obs);
    apb_xfer(1'b0, 12'h013, 32'h0, 4'h0, 1'b0, "rd offset", obs);
    check("rd offset value", {32'd0, obs}, 64'hDEADBEAA);

    // Out of range: index 48 and the very top of the address space.
    bus_idle(1);
    apb_xfer(1'b1, 12'h0C0, 32'hCAFEF00D, 4'hF, 1'b0, "wr oor", obs);
    apb_xfer(1'b0, 12'h0C0, 32'h0, 4'h0, 1'b0, "rd oor", obs);
    apb_xfer(1'b0, 12'hFFF, 32'h0, 4'h0, 1'b0, "rd top", obs);
    apb_xfer(1'b0, 12'h0BC, 32'h0, 4'h0, 1'b0, "rd last", obs);

    // Back-to-back write/read, then aborted writes leave the word alone.
    bus_idle(1);
    apb_xfer(1'b1, 12'h008, 32'h12345678, 4'hF, 1'b0, "b2b wr", obs);
    apb_xfer(1'b0, 12'h008, 32'h0, 4'h0, 1'b0, "b2b rd", obs);
    check("b2b rd value", {32'd0, obs}, 64'h12345678);
    bus_idle(1);
    apb_abort(12'h008, 32'hFFFFFFFF, 2, 1'b1, "abort psel");
    apb_abort(12'h008, 32'hFFFFFFFF, 3, 1'b0, "abort penable");
    apb_abort(12'h008, 32'hFFFFFFFF, 1, 1'b1, "abort early");
    apb_xfer(1'b0, 12'h008, 32'h0, 4'h0, 1'b0, "rd after abort", obs);
    check("rd after abort value", {32'd0, obs}, 64'h12345678);

    if (PAR_EN) begin
      apb_xfer(1'b1, 12'h020, 32'hA5C3_0F81, 4'hF, 1'b1, "par inj wr", obs);
      apb_xfer(1'b0, 12'h020, 32'h0, 4'h0, 1'b0, "par inj rd", obs);
      check("par inj data", {32'd0, obs}, 64'hA5C30F81);
      apb_xfer(1'b1, 12'h020, 32'h0000_0F81, 4'h3, 1'b0, "par fix lo", obs);
      apb_xfer(1'b0, 12'h020, 32'h0, 4'h0, 1'b0, "par half rd", obs);
      apb_xfer(1'b1, 12'h020, 32'hA5C3_0000, 4'hC, 1'b0, "par fix hi", obs);
      apb_xfer(1'b0, 12'h020, 32'h0, 4'h0, 1'b0, "par clean rd", obs);
    end

    // Random traffic against the model.
    for (int n = 0; n < 250; n++) begin
      int sel;
      logic [AW-1:0] a;
      sel = int'($urandom_range(0, 19));
      a = AW'($urandom_range(0, (NW + 6) * LANES - 1));
      if (sel == 0) begin
        bus_idle(1);
        apb_abort(a, $urandom, int'($urandom_range(1, WS)), sel[0] ^ 1'b1, "rnd abort");
      end else if (sel < 3) begin
        bus_idle(int'($urandom_range(1, 3)));
      end else begin
        apb_xfer(($urandom_range(0, 1) == 1), a, $urandom, LANES'($urandom),
                 PAR_EN && ($urandom_range(0, 7) == 0), "rnd", obs);
      end
    end

    // Reset in the middle of a write: transfer lost, storage cleared.
    bus_idle(1);
    apb_xfer(1'b1, 12'h01C, 32'h77665544, 4'hF, 1'b0, "pre rst wr", obs);
    bus_idle(1);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h01C;
    pwdata = 32'h0BADF00D; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk);
    check("mid rst outputs", {31'd0, pready, pslverr, prdata}, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1; psel = 1'b0; penable = 1'b0;
    ref_clear();
    @(negedge clk);
    check("post rst outputs", {31'd0, pready, pslverr, prdata}, 64'd0);
    apb_xfer(1'b0, 12'h01C, 32'h0, 4'h0, 1'b0, "rd after rst", obs);
    check("rd after rst value", {32'd0, obs}, 64'h0);

    // Refill a few words and sweep the whole array.
    for (int n = 0; n < 20; n++) begin
      apb_xfer(1'b1, AW'($urandom_range(0, NW * LANES - 1)), $urandom, LANES'($urandom),
               1'b0, "fill", obs);
    end
    for (int w = 0; w < int'(NW); w++) begin
      apb_xfer(1'b0, AW'(w * int'(LANES)), 32'h0, 4'h0, 1'b0, "sweep", obs);
    end
    bus_idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
